can_rx_frame_gen: RTL and testbench

Bit-level CAN 2.0A data/remote frame generator for the CAN-controller testbench. It sits directly upstream of the controller's `rx_i` pin. It accepts one frame descriptor per handshake and serialises it at a fixed bit period, with CRC-15 and bit stuffing, producing the levels the controller receives. During the ACK slot it samples the controller's `tx_o` and reports whether the frame was acknowledged.

---
 rtl/can_rx_frame_gen.sv | 175 +++++++++++++++++
 tb/tb_can_rx_frame_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_rx_frame_gen.sv
// CAN 2.0A data/remote frame generator driving a controller's rx pin.
// Serialises one descriptor per handshake with CRC-15, bit stuffing and ACK-slot sampling.
module can_rx_frame_gen #(
  parameter int BIT_CYCLES = 20,
  parameter int IFS_BITS   = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        ack_i,
  output logic        rx_o,
  output logic        bit_strobe,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_PRE  = CW'(BIT_CYCLES - 2);
  localparam logic [CW-1:0] CYC_MID  = CW'(BIT_CYCLES / 2);
  localparam logic [7:0]    EOF_LAST = 8'd6;
  localparam logic [7:0]    IFS_LAST = 8'(IFS_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIELD, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic nxt;
    nxt = b ^ c[14];
    return {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
  endfunction

  state_t          state;
  logic [CW-1:0]   cyc;
  logic [7:0]      bcnt;
  logic [6:0]      idx;
  logic [6:0]      crc_end;
  logic [6:0]      end_idx;
  logic [81:0]     sh;
  logic [14:0]     crc;
  logic [2:0]      run;
  logic            last_lvl;
  logic            ack_smp;
  logic [6:0]      n_data;
  logic            nxt_bit;
  logic            accept;
  logic            field_adv;

  // DLC 9..15 still sends eight bytes
  always_comb begin
    n_data    = rtr ? 7'd0 : (dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000});
    nxt_bit   = (idx < crc_end) ? sh[81] : crc[14];
    accept    = (state == S_IDLE) && frame_valid && frame_ready;
    field_adv = (state == S_FIELD) && (cyc == CYC_LAST) && (run != 3'd5) &&
                (idx != end_idx) && (idx < crc_end);
  end

  // Descriptor payload shifter: loaded on accept, advanced per unstuffed header/data bit
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sh      <= {id, rtr, 2'b00, dlc, data};
      crc_end <= 7'd19 + n_data;
      end_idx <= 7'd34 + n_data;
    end else if (field_adv) begin
      sh <= {sh[80:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cyc         <= '0;
      bcnt        <= '0;
      idx         <= '0;
      crc         <= '0;
      run         <= '0;
      last_lvl    <= 1'b1;
      ack_smp     <= 1'b0;
      rx_o        <= 1'b1;
      frame_ready <= 1'b1;
      busy        <= 1'b0;
      bit_strobe  <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      if (state != S_IDLE) cyc <= (cyc == CYC_LAST) ? '0 : cyc + 1'b1;
      unique case (state)
        S_IDLE: if (accept) begin
          // SOF goes out immediately and is the first CRC/stuff bit
          crc         <= crc_step(15'h0000, 1'b0);
          idx         <= 7'd1;
          run         <= 3'd1;
          last_lvl    <= 1'b0;
          rx_o        <= 1'b0;
          bit_strobe  <= 1'b1;
          busy        <= 1'b1;
          frame_ready <= 1'b0;
          cyc         <= '0;
          state       <= S_FIELD;
        end
        S_FIELD: if (cyc == CYC_LAST) begin
          bit_strobe <= 1'b1;
          if (run == 3'd5) begin
            rx_o     <= ~last_lvl;
            last_lvl <= ~last_lvl;
            run      <= 3'd1;
          end else if (idx == end_idx) begin
            rx_o  <= 1'b1;
            state <= S_CRC_DEL;
          end else begin
            rx_o     <= nxt_bit;
            last_lvl <= nxt_bit;
            run      <= (nxt_bit == last_lvl) ? run + 3'd1 : 3'd1;
            idx      <= idx + 7'd1;
            crc      <= (idx < crc_end) ? crc_step(crc, nxt_bit) : {crc[13:0], 1'b0};
          end
        end
        S_CRC_DEL: if (cyc == CYC_LAST) begin
          bit_strobe <= 1'b1;
          state      <= S_ACK;
        end
        S_ACK: begin
          if (cyc == CYC_MID) ack_smp <= ack_i;
          if (cyc == CYC_LAST) begin
            bit_strobe <= 1'b1;
            state      <= S_ACK_DEL;
          end
        end
        S_ACK_DEL: if (cyc == CYC_LAST) begin
          bit_strobe <= 1'b1;
          bcnt       <= '0;
          state      <= S_EOF;
        end
        S_EOF: if (cyc == CYC_LAST) begin
          bit_strobe <= 1'b1;
          if (bcnt == EOF_LAST) begin
            bcnt  <= '0;
            state <= S_IFS;
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
        S_IFS: begin
          // registered pulse lands on the final cycle of the last IFS bit
          if (cyc == CYC_PRE && bcnt == IFS_LAST) begin
            done    <= 1'b1;
            ack_err <= ack_smp;
          end
          if (cyc == CYC_LAST) begin
            if (bcnt == IFS_LAST) begin
              busy        <= 1'b0;
              frame_ready <= 1'b1;
              state       <= S_IDLE;
            end else begin
              bcnt       <= bcnt + 8'd1;
              bit_strobe <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_rx_frame_gen.sv
// Scoreboard bench for can_rx_frame_gen: a reference model pushes the expected line
// levels, frame length and ACK result per frame; a negedge monitor pops and compares.
module tb_can_rx_frame_gen;
  localparam int BC  = 20;
  localparam int IFS = 3;

  typedef bit bitq_t[$];

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [10:0] id = '0;
  logic        rtr = 1'b0;
  logic [3:0]  dlc = '0;
  logic [63:0] data = '0;
  logic        ack_i = 1'b0;
  logic        rx_o, bit_strobe, busy, done, ack_err;

  can_rx_frame_gen #(.BIT_CYCLES(BC), .IFS_BITS(IFS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .id(id), .rtr(rtr), .dlc(dlc), .data(data), .ack_i(ack_i), .rx_o(rx_o),
    .bit_strobe(bit_strobe), .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_cnt);
    end
  endtask

  bit    exp_bits[$];
  bit    exp_ack[$];
  int    exp_len[$];
  bitq_t line_q, last_line, s1_line;
  int    sof_cyc = 0;
  int    n_done = 0;
  bit    in_frame = 0;
  bit    prev_rx = 1;

  function automatic logic [14:0] crc15(input bitq_t q, input int n);
    logic [14:0] c;
    c = '0;
    for (int k = 0; k < n; k++) begin
      logic nx;
      nx = q[k] ^ c[14];
      c  = {c[13:0], 1'b0} ^ (nx ? 15'h4599 : 15'h0000);
    end
    return c;
  endfunction

  function automatic bitq_t destuff(input bitq_t q);
    bitq_t o;
    int    r;
    bit    l, skip;
    r = 0; l = 0; skip = 0;
    foreach (q[k]) begin
      if (skip) begin
        skip = 0; l = q[k]; r = 1;
      end else begin
        o.push_back(q[k]);
        if (r > 0 && q[k] == l) r++;
        else begin r = 1; l = q[k]; end
        if (r == 5) skip = 1;
      end
    end
    return o;
  endfunction

  // Reference: build the unstuffed field, append CRC, stuff, then add the fixed tail
  task automatic model_push(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                            input logic [63:0] fdata, input logic fack);
    bitq_t u;
    int    nd, run, n;
    bit    last;
    logic [14:0] c;
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(fid[i]);
    u.push_back(frtr); u.push_back(1'b0); u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(fdlc[i]);
    nd = frtr ? 0 : ((fdlc > 4'd8) ? 64 : 8 * int'(fdlc));
    for (int i = 0; i < nd; i++) u.push_back(fdata[63-i]);
    c = crc15(u, u.size());
    for (int i = 14; i >= 0; i--) u.push_back(c[i]);
    run = 0; last = 0; n = 0;
    foreach (u[k]) begin
      exp_bits.push_back(u[k]); n++;
      if (run > 0 && u[k] == last) run++;
      else begin run = 1; last = u[k]; end
      if (run == 5) begin
        exp_bits.push_back(~u[k]); n++;
        last = ~u[k]; run = 1;
      end
    end
    for (int i = 0; i < 10 + IFS; i++) exp_bits.push_back(1'b1);
    exp_len.push_back(n + 10 + IFS);
    exp_ack.push_back(fack);
  endtask

  // Monitor: compare every bit start, hold between strobes, and frame completion
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        in_frame = 0;
      end else begin
        if (bit_strobe) begin
          if (!in_frame) begin
            in_frame = 1; sof_cyc = cyc_cnt; line_q.delete();
          end
          line_q.push_back(rx_o);
          if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
          else chk("rx_bit", rx_o, exp_bits.pop_front());
        end else if (in_frame) begin
          chk("rx_hold", rx_o, prev_rx);
        end
        if (done) begin
          chk("done_ready_low", frame_ready, 0);
          if (exp_ack.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            int l;
            l = exp_len.pop_front();
            chk("ack_err", ack_err, exp_ack.pop_front());
            chk("done_time", cyc_cnt - sof_cyc, l * BC - 1);
            chk("bit_count", line_q.size(), l);
          end
          last_line = line_q;
          in_frame = 0;
          n_done++;
        end
      end
      prev_rx = rx_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                       input logic [63:0] fdata);
    id = fid; rtr = frtr; dlc = fdlc; data = fdata;
  endtask

  task automatic send(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                      input logic [63:0] fdata, input logic fack);
    int w;
    w = 0;
    @(negedge clk_i);
    while (!frame_ready && w < 4000) begin @(negedge clk_i); w++; end
    chk("ready_wait", frame_ready, 1);
    model_push(fid, frtr, fdlc, fdata, fack);
    drive(fid, frtr, fdlc, fdata);
    ack_i = fack;
    frame_valid = 1'b1;
    @(negedge clk_i);
    frame_valid = 1'b0;
    chk("acc_ready_low", frame_ready, 0);
    chk("acc_busy", busy, 1);
    chk("acc_strobe", bit_strobe, 1);
    chk("acc_sof", rx_o, 0);
  endtask

  task automatic wait_done();
    int start, w;
    start = n_done; w = 0;
    while (n_done == start && w < 3000) begin @(negedge clk_i); w++; end
    chk("done_timeout", n_done != start, 1);
    @(negedge clk_i);
    chk("ready_after_done", frame_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic check_frame(input logic [10:0] eid, input logic [3:0] edlc,
                             input logic [63:0] edata, input int nd);
    bitq_t d;
    logic [10:0] rid;
    logic [3:0]  rdlc;
    logic [63:0] rdata;
    logic [14:0] rcrc;
    d = destuff(last_line);
    chk("destuff_len", d.size() >= 34 + nd, 1);
    if (d.size() >= 34 + nd) begin
      rid = '0; rdlc = '0; rdata = '0; rcrc = '0;
      for (int i = 0; i < 11; i++) rid = {rid[9:0], d[1+i]};
      for (int i = 0; i < 4; i++) rdlc = {rdlc[2:0], d[15+i]};
      for (int i = 0; i < nd; i++) rdata[63-i] = d[19+i];
      for (int i = 0; i < 15; i++) rcrc = {rcrc[13:0], d[19+nd+i]};
      chk("line_id", rid, eid);
      chk("line_dlc", rdlc, edlc);
      chk("line_data", rdata, edata);
      chk("line_crc", rcrc, crc15(d, 19 + nd));
    end
  endtask

  initial begin
    int w, dcyc;
    // reset state
    #1 rst_i = 1'b1;
    #2;
    chk("rst_rx", rx_o, 1);
    chk("rst_ready", frame_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", bit_strobe, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;

    // all-zero frame: 40 stuffed field bits, 53 bits total
    send(11'h000, 1'b0, 4'd0, 64'h0, 1'b0);
    wait_done();
    chk("s1_total_bits", last_line.size(), 53);
    check_frame(11'h000, 4'd0, 64'h0, 0);
    s1_line = last_line;

    // all-ones identifier: stuff zeros inside the ID
    send(11'h7FF, 1'b0, 4'd0, 64'h0, 1'b0);
    wait_done();
    check_frame(11'h7FF, 4'd0, 64'h0, 0);

    // DLC above 8 clamps to eight data bytes
    send(11'h2A5, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, 1'b0);
    wait_done();
    check_frame(11'h2A5, 4'd15, 64'h0123_4567_89AB_CDEF, 64);

    // remote frame carries no data field
    send(11'h555, 1'b1, 4'd4, 64'hFFFF_0000_FFFF_0000, 1'b0);
    wait_done();

    // missing ACK, then acknowledged frame
    send(11'h123, 1'b0, 4'd2, 64'hA5F0_0000_0000_0000, 1'b1);
    wait_done();
    send(11'h123, 1'b0, 4'd2, 64'hA5F0_0000_0000_0000, 1'b0);
    wait_done();

    // asynchronous reset in the middle of bit 20
    send(11'h000, 1'b0, 4'd0, 64'h0, 1'b0);
    repeat (20 * BC + 3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_rx", rx_o, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", frame_ready, 1);
    exp_bits.delete(); exp_ack.delete(); exp_len.delete();
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b0;
    send(11'h000, 1'b0, 4'd0, 64'h0, 1'b0);
    wait_done();
    chk("post_rst_repeat", last_line == s1_line, 1);

    // valid held across two frames; second descriptor presented while busy
    @(negedge clk_i);
    model_push(11'h3C1, 1'b0, 4'd1, 64'h8100_0000_0000_0000, 1'b0);
    drive(11'h3C1, 1'b0, 4'd1, 64'h8100_0000_0000_0000);
    ack_i = 1'b0;
    frame_valid = 1'b1;
    @(negedge clk_i);
    chk("bp_first_acc", frame_ready, 0);
    model_push(11'h0F0, 1'b0, 4'd3, 64'h00FF_3C00_0000_0000, 1'b0);
    drive(11'h0F0, 1'b0, 4'd3, 64'h00FF_3C00_0000_0000);
    w = 0;
    while (!done && w < 3000) begin @(negedge clk_i); w++; end
    chk("bp_done_seen", done, 1);
    dcyc = cyc_cnt;
    @(negedge clk_i);
    chk("bp_ready_gap", frame_ready, 1);
    @(negedge clk_i);
    frame_valid = 1'b0;
    chk("bp_second_sof", rx_o, 0);
    chk("bp_second_strobe", bit_strobe, 1);
    chk("bp_second_busy", busy, 1);
    chk("bp_spacing", cyc_cnt - dcyc, 2);
    wait_done();
    check_frame(11'h0F0, 4'd3, 64'h00FF_3C00_0000_0000, 24);
    chk("queue_drained", exp_bits.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
